// File: rtl/bit_checksum_pkg.sv
// Shared widths and helpers for the bit_checksum lane-sum slice.
// Default DATA_W/CHK_W, lane count and full-width sum size.
package bit_checksum_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CHK_W  = 8;

  localparam int NUM_LANES = DEF_DATA_W / DEF_CHK_W;
  localparam int SUM_W     = DEF_CHK_W + $clog2(NUM_LANES);

  function automatic int lanes_of(input int dw, input int cw);
    return (cw > 0) ? dw / cw : 0;
  endfunction

  // Wide enough that adding every lane never overflows before truncation.
  function automatic int sum_w_of(input int dw, input int cw);
    return cw + $clog2(lanes_of(dw, cw));
  endfunction

endpackage

// File: rtl/bit_checksum_lane_sum.sv
// chk_lane_sum: combinational adder over the CHK_W-bit lanes of data.
// Ports: data [DATA_W] in, sum [SUM_W] out (full width, no carry loss).
module chk_lane_sum
  import bit_checksum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHK_W  = DEF_CHK_W,
  parameter int SUM_W  = sum_w_of(DEF_DATA_W, DEF_CHK_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic              unused_tie,
  output logic [SUM_W-1:0]  sum
);

  localparam int NL = lanes_of(DATA_W, CHK_W);

  always_comb begin
    sum = '0;
    for (int i = 0; i < NL; i++) begin
      sum = sum + SUM_W'(data[i*CHK_W +: CHK_W]);
    end
  end

endmodule

// File: rtl/bit_checksum.sv
// bit_checksum: registered modular sum of the CHK_W-bit lanes of data.
// Ports: clk, rst_n (async, active-low), data [DATA_W] in,
//   checksum [CHK_W] out (1-cycle latency), checksum_valid out.
// Build macro CHECKSUM_INVERT_EN: register the two's-complement
//   negation of the lane sum instead of the plain sum.
module bit_checksum
  import bit_checksum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHK_W  = DEF_CHK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  output logic [CHK_W-1:0]  checksum,
  output logic              checksum_valid
);

  localparam int SW = sum_w_of(DATA_W, CHK_W);

  generate
    if (CHK_W < 1 || DATA_W < CHK_W || (DATA_W % CHK_W) != 0) begin : g_bad
      $error("bit_checksum: DATA_W must be a nonzero multiple of CHK_W");
    end
  endgenerate

  logic [SW-1:0]    sum;
  logic [CHK_W-1:0] trunc;
  logic [CHK_W-1:0] result;

  chk_lane_sum #(
    .DATA_W (DATA_W),
    .CHK_W  (CHK_W),
    .SUM_W  (SW)
  ) u_sum (
    .data       (data),
    .unused_tie (1'b0),
    .sum        (sum)
  );

  // Carries above CHK_W are discarded; no end-around carry.
  assign trunc = sum[CHK_W-1:0];

  generate
    if (SW > CHK_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^sum[SW-1:CHK_W];
    end
  endgenerate

`ifdef CHECKSUM_INVERT_EN
  assign result = ~trunc + CHK_W'(1);
`else
  assign result = trunc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum       <= result;
      checksum_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_checksum.sv
// Bench for bit_checksum: directed vectors, reset, random streams.
// Covers 32-bit and 64-bit data instances against an integer model.
module tb_bit_checksum;

  logic        clk;
  logic        rst_n;
  logic [31:0] data32;
  logic [63:0] data64;
  logic [7:0]  checksum32;
  logic [7:0]  checksum64;
  logic        valid32;
  logic        valid64;

  int n_cmp;
  int n_err;

  bit_checksum #(.DATA_W(32), .CHK_W(8)) dut32 (
    .clk            (clk),
    .rst_n          (rst_n),
    .data           (data32),
    .checksum       (checksum32),
    .checksum_valid (valid32)
  );

  bit_checksum #(.DATA_W(64), .CHK_W(8)) dut64 (
    .clk            (clk),
    .rst_n          (rst_n),
    .data           (data64),
    .checksum       (checksum64),
    .checksum_valid (valid64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add byte values as integers, reduce mod 256, optionally negate.
  function automatic logic [7:0] model(input logic [63:0] d, input int lanes);
    int s;
    logic [63:0] t;
    s = 0;
    t = d;
    for (int i = 0; i < lanes; i++) begin
      s = s + int'(t & 64'hFF);
      t = t >> 8;
    end
    s = s % 256;
`ifdef CHECKSUM_INVERT_EN
    s = (256 - s) % 256;
`endif
    return 8'(s);
  endfunction

  task automatic test_reset();
    rst_n  = 1'b1;
    data32 = 32'h0102_0304;
    data64 = 64'h0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (checksum32 !== 8'h00 || valid32 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: got chk=%h v=%b want chk=00 v=0",
               checksum32, valid32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (valid32 !== 1'b0) begin
      n_err++;
      $display("FAIL valid_before_edge: got %b want 0", valid32);
    end
    @(negedge clk);
    n_cmp++;
    if (checksum32 !== model({32'h0, 32'h0102_0304}, 4) || valid32 !== 1'b1) begin
      n_err++;
      $display("FAIL first_edge: got chk=%h v=%b want chk=%h v=1",
               checksum32, valid32, model({32'h0, 32'h0102_0304}, 4));
    end
    // Mid-cycle assertion clears immediately, no clock edge needed.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (checksum32 !== 8'h00 || valid32 !== 1'b0 || valid64 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got chk=%h v=%b v64=%b want 00 0 0",
               checksum32, valid32, valid64);
    end
    @(negedge clk);
    data32 = 32'h0000_0000;
    rst_n  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid32 !== 1'b1 || valid64 !== 1'b1) begin
      n_err++;
      $display("FAIL valid_after_release: got %b/%b want 1/1",
               valid32, valid64);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [3];
    logic [7:0]  exp [3];
    vec[0] = 32'h0102_0304;
    vec[1] = 32'hFFFF_FFFF;
    vec[2] = 32'h0000_0000;
`ifdef CHECKSUM_INVERT_EN
    exp[0] = 8'hF6;
    exp[1] = 8'h04;
`else
    exp[0] = 8'h0A;
    exp[1] = 8'hFC;
`endif
    exp[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data32 = vec[i];
      @(negedge clk);
      n_cmp++;
      if (checksum32 !== exp[i]) begin
        n_err++;
        $display("FAIL directed_%0d: data=%h got %h want %h",
                 i, vec[i], checksum32, exp[i]);
      end
    end
  endtask

  task automatic test_walking();
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
`ifdef CHECKSUM_INVERT_EN
        exp = ((k - 1) % 2 == 0) ? 8'hFF : 8'hF0;
`else
        exp = ((k - 1) % 2 == 0) ? 8'h01 : 8'h10;
`endif
        n_cmp++;
        if (checksum32 !== exp) begin
          n_err++;
          $display("FAIL walk_%0d: got %h want %h", k - 1, checksum32, exp);
        end
      end
      data32 = 32'h1 << (4 * k);
    end
    @(negedge clk);
`ifdef CHECKSUM_INVERT_EN
    exp = 8'hF0;
`else
    exp = 8'h10;
`endif
    n_cmp++;
    if (checksum32 !== exp) begin
      n_err++;
      $display("FAIL walk_7: got %h want %h", checksum32, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev32;
    logic [63:0] prev64;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (checksum32 !== model({32'h0, prev32}, 4)) begin
          n_err++;
          $display("FAIL rand32_%0d: data=%h got %h want %h",
                   i, prev32, checksum32, model({32'h0, prev32}, 4));
        end
        n_cmp++;
        if (checksum64 !== model(prev64, 8)) begin
          n_err++;
          $display("FAIL rand64_%0d: data=%h got %h want %h",
                   i, prev64, checksum64, model(prev64, 8));
        end
      end
      prev32 = $urandom;
      prev64 = {$urandom, $urandom};
      data32 = prev32;
      data64 = prev64;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    data32 = '0;
    data64 = '0;
    test_reset();
    test_directed();
    test_walking();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
